// File: rtl/serial_collect_pkg.sv
// Shared types for serial collector stages: FSM state encoding and frame length.
// PARITY_CHECK_EN adds a trailing even-parity bit to every frame.
package serial_collect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// Word handshake between the serial collector (master) and its consumer (slave).
// PARITY_CHECK_EN adds the parity_err sideband.
interface serial_word_collector_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

  modport master (
`ifdef PARITY_CHECK_EN
    output parity_err,
`endif
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
`ifdef PARITY_CHECK_EN
    input  parity_err,
`endif
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/serial_word_collector_buffer.sv
// Single-entry valid/ready holding register; a load into a full, unaccepted
// buffer is dropped and raises a sticky overflow flag.
module word_out_buffer #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid,
  input  logic          ready,
  output logic          overflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // Accepting on the same edge frees the slot, so the new word goes in with no bubble.
      if (!valid || ready) begin
        dout  <= din;
        valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Assembles LSB-first serial bits into WIDTH-bit words and hands them off through
// a single-entry buffer. PARITY_CHECK_EN appends an even-parity bit per frame.
module serial_word_collector
  import serial_collect_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic clear,
  output logic busy,
  output logic overflow,
  serial_word_collector_if.master out_if
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DW    = frame_len(WIDTH);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [WIDTH-1:0]   shreg_q, shreg_n;
  logic               load;
  logic [WIDTH-1:0]   load_word;
  logic [DW-1:0]      buf_din;
  logic [DW-1:0]      buf_dout;
`ifdef PARITY_CHECK_EN
  logic               load_perr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      shreg_q <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    shreg_n   = shreg_q;
    load      = 1'b0;
    load_word = shreg_q;
`ifdef PARITY_CHECK_EN
    load_perr = 1'b0;
`endif
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      shreg_n = '0;
    end else if (bit_valid) begin
      case (state_q)
        IDLE: begin
          shreg_n = WIDTH'(bit_in);
          cnt_n   = CNT_W'(1);
          state_n = COLLECT;
        end
        COLLECT: begin
          // Upper bits are zero while collecting, so OR-ing places the bit at position cnt.
          shreg_n = shreg_q | (WIDTH'(bit_in) << cnt_q);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            cnt_n   = CNT_W'(WIDTH);
            state_n = PARITY;
`else
            load      = 1'b1;
            load_word = shreg_n;
            shreg_n   = '0;
            cnt_n     = '0;
            state_n   = IDLE;
`endif
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          load      = 1'b1;
          load_word = shreg_q;
          load_perr = (^shreg_q) ^ bit_in;
          shreg_n   = '0;
          cnt_n     = '0;
          state_n   = IDLE;
        end
`endif
        default: begin
          shreg_n = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy = (cnt_q != '0);

`ifdef PARITY_CHECK_EN
  assign buf_din           = {load_perr, load_word};
  assign out_if.parity_err = buf_dout[WIDTH];
`else
  assign buf_din = load_word;
`endif
  assign out_if.word_out = buf_dout[WIDTH-1:0];

  word_out_buffer #(
    .DW (DW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (buf_din),
    .dout     (buf_dout),
    .valid    (out_if.word_valid),
    .ready    (out_if.word_ready),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed and random checks of serial_word_collector against a bit-queue reference model.
// Build with PARITY_CHECK_EN to exercise the parity frame.
module tb_serial_word_collector;
  import serial_collect_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned FL = frame_len(W);

  logic clk, rst, bit_in, bit_valid, clear, busy, overflow;

  serial_word_collector_if #(.WIDTH(W)) bus ();

  serial_word_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .busy      (busy),
    .overflow  (overflow),
    .out_if    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: received bits kept as a queue, buffer as plain variables.
  bit          mbits[$];
  logic        mvalid, movf, mperr;
  logic [31:0] mword;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic bv, input logic b, input logic clr, input logic rdy);
    logic        ld;
    logic [31:0] nw;
    logic        p;
    rst = r; bit_valid = bv; bit_in = b; clear = clr; bus.word_ready = rdy;
    @(posedge clk);
    ld = 1'b0; nw = '0; p = 1'b0;
    if (r) begin
      mbits.delete();
      mvalid = 1'b0; movf = 1'b0; mword = '0; mperr = 1'b0;
    end else begin
      if (clr) mbits.delete();
      else if (bv) begin
        mbits.push_back(b);
        if (mbits.size() == FL) begin
          for (int i = 0; i < W; i++) nw[i] = mbits[i];
          for (int i = 0; i < FL; i++) p = p ^ mbits[i];
          ld = 1'b1;
          mbits.delete();
        end
      end
      if (ld) begin
        if (!mvalid || rdy) begin
          mvalid = 1'b1; mword = nw; mperr = p;
        end else movf = 1'b1;
      end else if (mvalid && rdy) mvalid = 1'b0;
    end
    #1;
    chk("word_valid", {31'b0, bus.word_valid}, {31'b0, mvalid});
    chk("word_out", {24'b0, bus.word_out}, mword);
    chk("busy", {31'b0, busy}, {31'b0, mbits.size() != 0});
    chk("overflow", {31'b0, overflow}, {31'b0, movf});
`ifdef PARITY_CHECK_EN
    chk("parity_err", {31'b0, bus.parity_err}, {31'b0, mperr});
`endif
  endtask

  // One frame; gaps inserts an idle cycle (with a decoy bit) before every bit after the first.
  task automatic send_word(input logic [31:0] w, input logic rdy, input logic rdy_last,
                           input logic pflip, input logic gaps);
    logic b;
    for (int i = 0; i < FL; i++) begin
      b = (i < W) ? w[i] : ((^w[W-1:0]) ^ pflip);
      if (gaps && i > 0) step(1'b0, 1'b0, ~b, 1'b0, rdy);
      step(1'b0, 1'b1, b, 1'b0, (i == FL - 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0; bus.word_ready = 1'b0;
    mvalid = 1'b0; movf = 1'b0; mword = '0; mperr = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", {31'b0, bus.word_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_word", {24'b0, bus.word_out}, 32'd0);

    // 1,0,1,1,0,0,1,0 LSB-first
    send_word(32'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_word", {24'b0, bus.word_out}, 32'h4D);
    chk("t1_valid", {31'b0, bus.word_valid}, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_consumed", {31'b0, bus.word_valid}, 32'd0);

    send_word(32'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_gap_word", {24'b0, bus.word_out}, 32'h96);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send_word(32'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_word", {24'b0, bus.word_out}, 32'hA5);
    chk("t3_ovf", {31'b0, overflow}, 32'd1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_stable", {24'b0, bus.word_out}, 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_drained", {31'b0, bus.word_valid}, 32'd0);
    chk("t3_ovf_sticky", {31'b0, overflow}, 32'd1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_word", {24'b0, bus.word_out}, 32'h22);
    chk("t4_valid", {31'b0, bus.word_valid}, 32'd1);
    chk("t4_ovf", {31'b0, overflow}, 32'd0);

    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_clr_busy", {31'b0, busy}, 32'd0);
    chk("t5_clr_keep", {24'b0, bus.word_out}, 32'h22);
    chk("t5_clr_valid", {31'b0, bus.word_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(32'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_clean", {24'b0, bus.word_out}, 32'h5A);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_rst_valid", {31'b0, bus.word_valid}, 32'd0);
    send_word(32'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_rst_clean", {24'b0, bus.word_out}, 32'hC3);

`ifdef PARITY_CHECK_EN
    send_word(32'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_par_ok", {31'b0, bus.parity_err}, 32'd0);
    send_word(32'h4D, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_par_bad", {31'b0, bus.parity_err}, 32'd1);
`endif

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
